// File: rtl/inv_stim_sequencer.sv
// Stimulus sequencer for the analog double-inverter cell: toggles the cell input,
// watches the synchronised response, and tallies errors and worst round-trip latency.
module inv_stim_sequencer #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200,
    parameter int HOLD_CYC    = 4,
    parameter bit INVERT      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [CNT_W-1:0] n_toggles,
    input  logic             resp_in,
    output logic             stim_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] lat_max
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_HOLD, S_DONE} state_t;

    localparam int                HOLD_W       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SYNC_DEPTH   = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    state_t              state;
    state_t              state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                resp_sync;
    logic                expected;
    logic                resp_match;
    logic                wait_ok;
    logic                timed_out;
    logic                hold_end;
    logic                last_toggle;
    logic [CNT_W-1:0]    n_lat;
    logic [CNT_W-1:0]    toggles_done;
    logic [CNT_W-1:0]    lat_cnt;
    logic [CNT_W-1:0]    lat_now;
    logic [HOLD_W-1:0]   hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], resp_in};
        end
    end

    assign resp_sync   = sync_q[SYNC_STAGES-1];
    assign expected    = stim_out ^ INVERT;
    assign resp_match  = (resp_sync == expected);
    // Until SYNC_STAGES cycles have passed, resp_sync still carries pre-toggle samples;
    // accepting them would let a dead or wrong-polarity cell look like a fast one.
    assign wait_ok     = resp_match && (lat_cnt >= SYNC_DEPTH);
    assign timed_out   = (lat_cnt == TIMEOUT_LAST);
    assign hold_end    = (hold_cnt == HOLD_LAST);
    assign last_toggle = (toggles_done == n_lat);
    assign lat_now     = lat_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!ena) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (start) state_next = S_ARM;
                S_ARM:  if (resp_match || timed_out) state_next = S_HOLD;
                S_WAIT: if (wait_ok || timed_out) state_next = S_HOLD;
                S_HOLD: if (hold_end) state_next = last_toggle ? S_DONE : S_WAIT;
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_out     <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            lat_max      <= '0;
            n_lat        <= '0;
            toggles_done <= '0;
            lat_cnt      <= '0;
            hold_cnt     <= '0;
        end else begin
            hold_cnt <= (state == S_HOLD && !hold_end) ? hold_cnt + HOLD_W'(1) : '0;
            if (!ena) begin
                // Abort keeps the statistics of the interrupted run visible.
                stim_out <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        lat_cnt <= '0;
                        if (start) begin
                            n_lat        <= n_toggles;
                            toggles_done <= '0;
                            err_count    <= '0;
                            lat_max      <= '0;
                            pass         <= 1'b0;
                        end
                    end
                    S_ARM, S_WAIT: begin
                        if ((state == S_ARM) ? resp_match : wait_ok) begin
                            if (state == S_WAIT && lat_now > lat_max) lat_max <= lat_now;
                        end else if (timed_out) begin
                            if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                        end else begin
                            lat_cnt <= lat_now;
                        end
                    end
                    S_HOLD: begin
                        if (hold_end) begin
                            if (last_toggle) begin
                                pass     <= (err_count == '0);
                                stim_out <= 1'b0;
                            end else begin
                                stim_out     <= ~stim_out;
                                toggles_done <= toggles_done + CNT_W'(1);
                                lat_cnt      <= '0;
                            end
                        end
                    end
                    S_DONE: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inv_stim_sequencer.sv
// Directed bench for inv_stim_sequencer: behavioural cell models on resp_in,
// hand-computed run statistics, edge and done-pulse monitors.
`timescale 1ns/1ps
module tb_inv_stim_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             start = 1'b0;
    logic             start_inv = 1'b0;
    logic [CNT_W-1:0] n_toggles = '0;
    logic             resp_in;
    logic             resp_inv;
    logic             stim_out, busy, done, pass;
    logic [CNT_W-1:0] err_count, lat_max;
    logic             stim_inv, busy_inv, done_inv, pass_inv;
    logic [CNT_W-1:0] err_inv, lat_inv;

    int               resp_mode = 0;
    logic [9:0]       dly = '0;
    int               n_cmp = 0;
    int               n_mis = 0;
    int               edge_cnt = 0;
    int               done_cnt = 0;
    logic             prev_stim = 1'b0;
    logic [31:0]      exp_q[$];

    inv_stim_sequencer #(.INVERT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .n_toggles(n_toggles),
        .resp_in(resp_in), .stim_out(stim_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .lat_max(lat_max)
    );

    inv_stim_sequencer #(.INVERT(1'b1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start_inv), .n_toggles(n_toggles),
        .resp_in(resp_inv), .stim_out(stim_inv), .busy(busy_inv), .done(done_inv),
        .pass(pass_inv), .err_count(err_inv), .lat_max(lat_inv)
    );

    // Clock and cell models: 0 wire, 1 ten-cycle delay, 2 stuck low, 3 inverter.
    always #5 clk = ~clk;

    always @(posedge clk) dly <= {dly[8:0], stim_out};

    always_comb begin
        resp_in = stim_out;
        case (resp_mode)
            0:       resp_in = stim_out;
            1:       resp_in = dly[9];
            2:       resp_in = 1'b0;
            default: resp_in = ~stim_out;
        endcase
    end

    assign resp_inv = ~stim_inv;

    always @(negedge clk) begin
        if (!done && stim_out != prev_stim) edge_cnt <= edge_cnt + 1;
        prev_stim <= stim_out;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit to_inv, input logic [CNT_W-1:0] n);
        @(negedge clk);
        n_toggles = n;
        if (to_inv) start_inv = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_inv = 1'b0;
    endtask

    task automatic wait_done(input bit on_inv, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((on_inv ? done_inv : done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(on_inv ? done_inv : done), 32'd0);
        check({tag, "_busy_drop"}, 32'(on_inv ? busy_inv : busy), 32'd0);
    endtask

    task automatic wait_edges(input int target, input string tag);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (edge_cnt >= target) begin
                reached = 1'b1;
                break;
            end
        end
        check({tag, "_edge_reached"}, 32'(reached), 32'd1);
    endtask

    task automatic expect_run(input string tag, input bit on_inv,
                              input logic [31:0] e_pass, input logic [31:0] e_err,
                              input logic [31:0] e_lat);
        exp_q.push_back(e_pass);
        exp_q.push_back(e_err);
        exp_q.push_back(e_lat);
        check({tag, "_pass"}, 32'(on_inv ? pass_inv : pass), exp_q.pop_front());
        check({tag, "_err_count"}, 32'(on_inv ? err_inv : err_count), exp_q.pop_front());
        check({tag, "_lat_max"}, 32'(on_inv ? lat_inv : lat_max), exp_q.pop_front());
    endtask

    task automatic run_main(input int mode, input logic [CNT_W-1:0] n, input string tag,
                            input int e_edges, input logic [31:0] e_pass,
                            input logic [31:0] e_err, input logic [31:0] e_lat);
        int e0, d0;
        resp_mode = mode;
        repeat (12) @(negedge clk);
        e0 = edge_cnt;
        d0 = done_cnt;
        pulse_start(1'b0, n);
        wait_done(1'b0, tag);
        repeat (2) @(negedge clk);
        check({tag, "_edges"}, 32'(edge_cnt - e0), 32'(e_edges));
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        expect_run(tag, 1'b0, e_pass, e_err, e_lat);
    endtask

    initial begin
        int e0, d0;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stim", 32'(stim_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        expect_run("rst", 1'b0, 0, 0, 0);
        rst_n = 1'b1;

        // start with ena low is ignored
        pulse_start(1'b0, 8'd3);
        check("ena_low_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("ena_low_busy_later", 32'(busy), 32'd0);
        ena = 1'b1;

        // Ideal wire, ten-cycle delay, stuck-low cell, inverting cell on non-inverting DUT
        run_main(0, 8'd4, "wire", 4, 1, 0, 3);
        run_main(1, 8'd2, "delay10", 2, 1, 0, 13);
        run_main(2, 8'd4, "stuck0", 4, 0, 2, 3);
        run_main(3, 8'd3, "wrong_pol", 3, 0, 4, 0);

        // Inverting cell on the INVERT=1 instance
        repeat (4) @(negedge clk);
        pulse_start(1'b1, 8'd3);
        wait_done(1'b1, "inv");
        expect_run("inv", 1'b1, 1, 0, 3);

        // ena dropped during WAIT of toggle 2, then a clean restart
        resp_mode = 0;
        repeat (12) @(negedge clk);
        e0 = edge_cnt;
        d0 = done_cnt;
        pulse_start(1'b0, 8'd4);
        wait_edges(e0 + 2, "abort");
        ena = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_stim", 32'(stim_out), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        expect_run("abort_kept", 1'b0, 0, 0, 3);
        ena = 1'b1;
        @(negedge clk);
        e0 = edge_cnt;
        pulse_start(1'b0, 8'd4);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_lat_cleared", 32'(lat_max), 32'd0);
        wait_done(1'b0, "restart");
        repeat (2) @(negedge clk);
        check("restart_edges", 32'(edge_cnt - e0), 32'd4);
        expect_run("restart", 1'b0, 1, 0, 3);

        // start while busy is ignored
        e0 = edge_cnt;
        d0 = done_cnt;
        pulse_start(1'b0, 8'd2);
        repeat (5) @(negedge clk);
        n_toggles = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, "busy_start");
        repeat (4) @(negedge clk);
        check("busy_start_edges", 32'(edge_cnt - e0), 32'd2);
        check("busy_start_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_start_idle", 32'(busy), 32'd0);
        expect_run("busy_start", 1'b0, 1, 0, 3);

        // Asynchronous reset in WAIT of toggle 3 (stim high, lat_max already 3)
        e0 = edge_cnt;
        pulse_start(1'b0, 8'd4);
        wait_edges(e0 + 3, "mid_rst");
        check("mid_rst_pre_stim", 32'(stim_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_stim", 32'(stim_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        expect_run("mid_rst", 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero toggles: ARM, one HOLD, DONE
        run_main(0, 8'd0, "zero", 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
